// File: rtl/ram_banked_if.sv
// Access bus for ram_banked: request, write data, registered read data and status.
interface ram_banked_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
);
  logic              en;
  logic              rw;
  logic              clr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              busy;
  logic              parity_err;

  modport master (
    output en, rw, clr, address, in,
    input  out, out_valid, busy, parity_err
  );

  modport slave (
    input  en, rw, clr, address, in,
    output out, out_valid, busy, parity_err
  );
endinterface

// File: rtl/ram_banked.sv
// Banked single-port RAM with registered read, valid strobe and hardware zero-fill.
// Optional per-word even parity with read check when RAM_PARITY_EN is defined.
module ram_banked #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BANK_BITS = 3
) (
  input logic         clk,
  input logic         rst,
  ram_banked_if.slave bus
);
  localparam int unsigned IDX_W      = ADDR_W - BANK_BITS;
  localparam int unsigned BANKS      = 1 << BANK_BITS;
  localparam int unsigned BANK_DEPTH = 1 << IDX_W;

  typedef enum logic {FILL, IDLE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  fill_cnt;
  logic [DATA_W-1:0] mem [BANKS][BANK_DEPTH];
`ifdef RAM_PARITY_EN
  logic              mem_par [BANKS][BANK_DEPTH];
`endif

  logic [BANK_BITS-1:0] bank_sel_c;
  logic [IDX_W-1:0]     idx_c;
  logic                 wr_c;
  logic                 rd_c;

  // MSBs pick the bank, the rest index within it; clr wins over any access
  assign bank_sel_c = bus.address[ADDR_W-1 -: BANK_BITS];
  assign idx_c      = bus.address[IDX_W-1:0];
  assign wr_c       = (state == IDLE) && bus.en && !bus.clr && bus.rw;
  assign rd_c       = (state == IDLE) && bus.en && !bus.clr && !bus.rw;

  // Storage: all banks cleared in parallel while filling, else a single-bank write
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        mem[BANK_BITS'(b)][fill_cnt] <= '0;
`ifdef RAM_PARITY_EN
        mem_par[BANK_BITS'(b)][fill_cnt] <= 1'b0;
`endif
      end
    end else if (wr_c) begin
      mem[bank_sel_c][idx_c] <= bus.in;
`ifdef RAM_PARITY_EN
      mem_par[bank_sel_c][idx_c] <= ^bus.in;
`endif
    end
  end

  // Control FSM with registered read port and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FILL;
      fill_cnt       <= '0;
      bus.busy       <= 1'b1;
      bus.out        <= '0;
      bus.out_valid  <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.parity_err <= 1'b0;
      if (bus.clr) begin
        state    <= FILL;
        fill_cnt <= '0;
        bus.busy <= 1'b1;
      end else begin
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == '1) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
          IDLE: begin
            bus.busy <= 1'b0;
            if (rd_c) begin
              bus.out       <= mem[bank_sel_c][idx_c];
              bus.out_valid <= 1'b1;
`ifdef RAM_PARITY_EN
              bus.parity_err <= (^mem[bank_sel_c][idx_c]) != mem_par[bank_sel_c][idx_c];
`endif
            end
          end
          default: begin
            state    <= FILL;
            fill_cnt <= '0;
            bus.busy <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ram_banked.sv
// Self-checking bench for ram_banked: behavioural memory model, per-cycle compare, directed + random stimulus.
module tb_ram_banked;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned BANK_BITS = 3;
  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam int          FILL_CYC  = 1 << (ADDR_W - BANK_BITS);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_banked_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_banked #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_BITS(BANK_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Behavioural model: memory image, remaining fill cycles, expected outputs
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_bad [DEPTH];
  int                fill_left;
  bit                idle_before;
  logic [DATA_W-1:0] e_out;
  bit                e_valid, e_busy, e_perr;

  function automatic void fill_start();
    fill_left = FILL_CYC;
    e_busy    = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_start();
      e_out   = '0;
      e_valid = 1'b0;
      e_perr  = 1'b0;
    end else begin
      idle_before = (fill_left == 0);
      e_valid     = 1'b0;
      e_perr      = 1'b0;
      if (bus.clr) begin
        fill_start();
      end else begin
        if (fill_left > 0) fill_left--;
        if (idle_before && bus.en) begin
          if (bus.rw) begin
            m_mem[bus.address] = bus.in;
            m_bad[bus.address] = 1'b0;
          end else begin
            e_out   = m_mem[bus.address];
            e_valid = 1'b1;
            e_perr  = m_bad[bus.address];
          end
        end
      end
      e_busy = (fill_left > 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(e_busy));
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("out", 32'(bus.out), 32'(e_out));
      check("parity_err", 32'(bus.parity_err), 32'(e_perr));
    end
  end

  task automatic step(input bit en, input bit rw, input bit clr,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.en      = en;
    bus.rw      = rw;
    bus.clr     = clr;
    bus.address = a;
    bus.in      = d;
    @(negedge clk);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    step(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    step(1'b1, 1'b0, 1'b0, a, '0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      idle();
    end
  endtask

  int nb;
  logic [ADDR_W-1:0] ra;

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.rw      = 1'b0;
    bus.clr     = 1'b0;
    bus.address = '0;
    bus.in      = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_out", 32'(bus.out), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h1);
    rst = 1'b0;

    // Fill after reset, then every word reads zero
    count_busy(nb);
    check("fill_len_reset", 32'(nb), 32'(FILL_CYC));
    for (int a = 0; a < int'(DEPTH); a++) rd(ADDR_W'(a));
    check("fill_last_valid", 32'(bus.out_valid), 32'h1);
    check("fill_last_out", 32'(bus.out), 32'h0);

    // Per-bank write/read
    wr(9'h000, 16'hA5A5);
    wr(9'h1C0, 16'h01C0);
    wr(9'h1FF, 16'hFFFF);
    check("wr_no_valid", 32'(bus.out_valid), 32'h0);
    rd(9'h000); check("rd_000", 32'(bus.out), 32'hA5A5);
    rd(9'h1C0); check("rd_1c0", 32'(bus.out), 32'h01C0);
    rd(9'h1FF); check("rd_1ff", 32'(bus.out), 32'hFFFF);
    rd(9'h001); check("rd_001", 32'(bus.out), 32'h0000);
    rd(9'h1BF); check("rd_1bf", 32'(bus.out), 32'h0000);

    // Back-to-back reads
    wr(9'h010, 16'h1111);
    wr(9'h011, 16'h2222);
    wr(9'h012, 16'h3333);
    rd(9'h010); check("b2b_v0", 32'(bus.out_valid), 32'h1); check("b2b_d0", 32'(bus.out), 32'h1111);
    rd(9'h011); check("b2b_v1", 32'(bus.out_valid), 32'h1); check("b2b_d1", 32'(bus.out), 32'h2222);
    rd(9'h012); check("b2b_v2", 32'(bus.out_valid), 32'h1); check("b2b_d2", 32'(bus.out), 32'h3333);
    idle();     check("b2b_hold_v", 32'(bus.out_valid), 32'h0); check("b2b_hold_d", 32'(bus.out), 32'h3333);

    // clr beats a simultaneous write; busy blocks accesses
    wr(9'h040, 16'h1234);
    step(1'b1, 1'b1, 1'b1, 9'h041, 16'hBEEF);
    rd(9'h040);
    check("busy_read_dropped", 32'(bus.out_valid), 32'h0);
    count_busy(nb);
    check("fill_len_clr", 32'(nb + 1), 32'(FILL_CYC));
    rd(9'h040); check("clr_040", 32'(bus.out), 32'h0);
    rd(9'h041); check("clr_041", 32'(bus.out), 32'h0);

    // Reset in the middle of a fill
    wr(9'h005, 16'h3C3C);
    rd(9'h005);
    check("pre_rst_out", 32'(bus.out), 32'h3C3C);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    for (int i = 0; i < 30; i++) idle();
    check("midfill_out_held", 32'(bus.out), 32'h3C3C);
    #2 rst = 1'b1;
    #1;
    check("midfill_rst_out", 32'(bus.out), 32'h0);
    check("midfill_rst_busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_busy(nb);
    check("fill_len_midrst", 32'(nb), 32'(FILL_CYC));

    // Random traffic, biased to a few addresses for read-after-write hits
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom_range(0, DEPTH - 1));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 299) == 0), ra, DATA_W'($urandom));
    end
    count_busy(nb);

`ifdef RAM_PARITY_EN
    // Corrupt a stored bit behind the parity and read it back
    wr(9'h001, 16'h0001);
    wr(9'h000, 16'h0003);
    dut.mem[0][1] = dut.mem[0][1] ^ 16'h0001;
    m_mem[1] = 16'h0000;
    m_bad[1] = 1'b1;
    rd(9'h001);
    check("par_err_valid", 32'(bus.out_valid), 32'h1);
    check("par_err", 32'(bus.parity_err), 32'h1);
    rd(9'h000);
    check("par_ok", 32'(bus.parity_err), 32'h0);
    idle();
    check("par_idle", 32'(bus.parity_err), 32'h0);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_banked.md
Name: ram_banked

Overview:
- Parametrised single-port synchronous RAM: DATA_W-bit words, 2^ADDR_W depth, split into 2^BANK_BITS banks selected by the address MSBs.
- Successor to the fixed 16-bit/512-word banked RAM: registered read with a valid strobe, a hardware zero-fill sequencer on reset or on command, and a busy indicator.
- Sits as the main data store under the memory controller. Slots in where the fixed-size banked RAMs are used today.

Parameters:
- DATA_W, 16, word width in bits (>=1).
- ADDR_W, 9, address width; depth = 2^ADDR_W words.
- BANK_BITS, 3, bank-select bits taken from address[ADDR_W-1 -: BANK_BITS]; banks = 2^BANK_BITS; must be < ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  access request, sampled at rising clk.
- rw  in  1  1 = write, 0 = read (qualified by en).
- clr  in  1  synchronous pulse: restart zero-fill sequence.
- address  in  ADDR_W  word address.
- in  in  DATA_W  write data.
- out  out  DATA_W  registered read data.
- out_valid  out  1  one-cycle strobe: out holds fresh read data.
- busy  out  1  zero-fill in progress; accesses ignored.
- parity_err  out  1  read parity mismatch (see Optional Feature).

Behaviour:
- Reset (async assert): out=0, out_valid=0, parity_err=0, busy=1, state=FILL, fill counter=0. Memory contents are not touched by rst itself; the FILL sequence zeroes them.
- States: FILL, IDLE.
- FILL:
  - Each cycle writes 0 to local index fill_cnt in every bank in parallel, then increments fill_cnt (width ADDR_W-BANK_BITS).
  - Takes exactly 2^(ADDR_W-BANK_BITS) cycles after rst deassertion; defaults give 64 cycles.
  - On the cycle the last index is written, go to IDLE. busy drops on the following edge's output.
  - busy=1 throughout FILL.
- IDLE: busy=0.
  - en=1, rw=1: mem[address] <= in at this edge. out unchanged; out_valid=0 next cycle.
  - en=1, rw=0: out <= mem[address] at this edge; out_valid=1 for exactly one cycle. Latency is 1 clock from the request edge to valid data.
  - en=0: out holds its last value; out_valid=0.
- Bank decode: only the bank addressed by the MSBs is enabled. The remaining ADDR_W-BANK_BITS bits index within the bank. Non-selected banks see no write.
- Accesses while busy=1 are dropped silently. out and out_valid are not affected; out_valid stays 0.
- clr=1 in any state: at that edge go to FILL with fill_cnt=0 and busy=1. clr takes priority over a simultaneous en, which is dropped. clr during FILL restarts the count from 0.
- Address wrap: none. The full address range is valid and no out-of-range case exists.
- Reset mid-FILL or mid-read: all outputs return to their reset values immediately. FILL restarts from 0 after deassertion.

Optional Feature:
- Macro RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from in on write (0 for FILL writes).
  - On read, parity_err is registered alongside out and pulses with out_valid when the recomputed parity differs from the stored bit.
  - parity_err resets to 0 and is 0 whenever out_valid=0.
- Not defined: no parity storage; parity_err is tied to 0.

Test Plan:
- Fill after reset: assert rst for 2 cycles, release → busy=1 for exactly 64 cycles, then 0. Read of all 512 addresses returns 0x0000, each with out_valid pulsed 1 cycle after its request.
- Write/read per bank: write 0xA5A5 to 0x000, 0x1C0 to 0x1C0, 0xFFFF to 0x1FF → reads return the same values with 1-cycle latency. Adjacent addresses 0x001 and 0x1BF read 0.
- Busy blocking: write 0x1234 to 0x040, pulse clr together with a write of 0xBEEF to 0x041 → the 0x041 write is dropped. After 64 busy cycles, 0x040 and 0x041 both read 0.
- Back-to-back reads: read 0x010, 0x011, 0x012 on consecutive cycles → out_valid high for 3 consecutive cycles with the matching data. out holds the 0x012 data afterwards with out_valid=0.
- Reset mid-FILL: assert rst at FILL cycle 30 → out=0 and busy=1 immediately. After release, busy lasts a full 64 cycles.
- Parity (RAM_PARITY_EN defined): write 0x0001, force-flip the stored data bit via hierarchical reference, read → parity_err=1 coincident with out_valid. Reading an unmodified word → parity_err=0.
